// File: rtl/easyaxi_slv_rd_ctrl.sv
// AXI slave read controller: in-order AR queue feeding a beat generator that returns arlen+1 R beats of address-pattern data.
// First rvalid two cycles after the AR handshake; R payload is registered and held while rready is low, AR stalls only when the queue is full.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_rd_ctrl #(
  parameter int                     OST_DEPTH     = 4,
  parameter logic [`AXI_ADDR_W-1:0] ADDR_LIMIT    = `AXI_ADDR_W'h100,
  parameter int                     MAX_BURST_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    axi_slv_arvalid,
  output logic                    axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]    axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]  axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]   axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]  axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0] axi_slv_arburst,
  input  logic [`AXI_USER_W-1:0]  axi_slv_aruser,
  output logic                    axi_slv_rvalid,
  input  logic                    axi_slv_rready,
  output logic [`AXI_ID_W-1:0]    axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]  axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]  axi_slv_rresp,
  output logic                    axi_slv_rlast,
  output logic [`AXI_USER_W-1:0]  axi_slv_ruser
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = $clog2(OST_DEPTH) + 1;
  localparam int AW = `AXI_ADDR_W;
  localparam int DW = `AXI_DATA_W;
  localparam int LW = `AXI_LEN_W;
  localparam int RW = `AXI_RESP_W;

  localparam logic [`AXI_BURST_W-1:0] BURST_FIXED = 'd0;
  localparam logic [`AXI_BURST_W-1:0] BURST_WRAP  = 'd2;
  localparam logic [`AXI_BURST_W-1:0] BURST_RSVD  = 'd3;
  localparam logic [RW-1:0] RESP_OKAY   = 'd0;
  localparam logic [RW-1:0] RESP_SLVERR = 'd2;
  localparam logic [RW-1:0] RESP_DECERR = 'd3;

  typedef struct packed {
    logic [`AXI_ID_W-1:0]    id;
    logic [AW-1:0]           addr;
    logic [LW-1:0]           len;
    logic [`AXI_SIZE_W-1:0]  size;
    logic [`AXI_BURST_W-1:0] burst;
    logic [`AXI_USER_W-1:0]  user;
  } ar_t;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  function automatic logic f_wrap_ok(input logic [LW-1:0] l);
    return (l == LW'(1)) || (l == LW'(3)) || (l == LW'(7)) || (l == LW'(15));
  endfunction

  function automatic logic [RW-1:0] f_resp(input logic [AW-1:0] a, input logic [LW-1:0] l,
                                           input logic [`AXI_BURST_W-1:0] b);
    if (a >= ADDR_LIMIT)                                   return RESP_DECERR;
    if (l > LW'(MAX_BURST_LEN - 1))                        return RESP_SLVERR;
    if ((b == BURST_WRAP && !f_wrap_ok(l)) || b == BURST_RSVD) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [DW-1:0] f_data(input logic [AW-1:0] a);
    return (a >= ADDR_LIMIT) ? '0 : DW'(a);
  endfunction

  ar_t                    r_mem [OST_DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_cnt;
  state_t                 r_state;
  logic [AW-1:0]          r_cur_addr;
  logic [LW-1:0]          r_len, r_beat_cnt;
  logic [`AXI_SIZE_W-1:0] r_size;
  logic [`AXI_BURST_W-1:0] r_burst;
  logic                   r_rvalid, r_rlast;
  logic [`AXI_ID_W-1:0]   r_rid;
  logic [DW-1:0]          r_rdata;
  logic [RW-1:0]          r_rresp;
  logic [`AXI_USER_W-1:0] r_ruser;

  logic          w_full, w_empty, w_push, w_pop, w_rhs;
  ar_t           w_ar, w_head;
  logic [AW-1:0] w_bytes, w_incr, w_wmask, w_nxt_addr;
  logic [LW-1:0] w_cnt_nxt;

  // Full comes from the registered count, so a same-cycle pop never re-opens arready.
  assign w_full  = (r_cnt == CW'(OST_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = axi_slv_arvalid & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  assign w_rhs   = r_rvalid & axi_slv_rready;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_ar    = '{id: axi_slv_arid, addr: axi_slv_araddr, len: axi_slv_arlen,
                     size: axi_slv_arsize, burst: axi_slv_arburst, user: axi_slv_aruser};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_ar;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Illegal-length WRAP and the reserved burst type fall through to INCR stepping.
  always_comb begin
    w_bytes    = AW'(1) << r_size;
    w_incr     = r_cur_addr + w_bytes;
    w_wmask    = ((AW'(r_len) + AW'(1)) << r_size) - AW'(1);
    w_nxt_addr = w_incr;
    if (r_burst == BURST_FIXED)
      w_nxt_addr = r_cur_addr;
    else if (r_burst == BURST_WRAP && f_wrap_ok(r_len))
      w_nxt_addr = (r_cur_addr & ~w_wmask) | (w_incr & w_wmask);
    w_cnt_nxt = r_beat_cnt + LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= 1'b0;
      r_rlast    <= 1'b0;
      r_rid      <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_ruser    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_state    <= S_BURST;
            r_cur_addr <= w_head.addr;
            r_len      <= w_head.len;
            r_size     <= w_head.size;
            r_burst    <= w_head.burst;
            r_beat_cnt <= '0;
            r_rvalid   <= 1'b1;
            r_rlast    <= (w_head.len == '0);
            r_rid      <= w_head.id;
            r_ruser    <= w_head.user;
            r_rdata    <= f_data(w_head.addr);
            r_rresp    <= f_resp(w_head.addr, w_head.len, w_head.burst);
          end
        end
        S_BURST: begin
          if (w_rhs) begin
            if (r_rlast) begin
              r_state  <= S_IDLE;
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
            end else begin
              r_cur_addr <= w_nxt_addr;
              r_beat_cnt <= w_cnt_nxt;
              r_rlast    <= (w_cnt_nxt == r_len);
              r_rdata    <= f_data(w_nxt_addr);
              r_rresp    <= f_resp(w_nxt_addr, r_len, r_burst);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign axi_slv_arready = ~w_full;
  assign axi_slv_rvalid  = r_rvalid;
  assign axi_slv_rlast   = r_rlast;
  assign axi_slv_rid     = r_rid;
  assign axi_slv_rdata   = r_rdata;
  assign axi_slv_rresp   = r_rresp;
  assign axi_slv_ruser   = r_ruser;

endmodule

// File: tb/tb_easyaxi_slv_rd_ctrl.sv
// Directed bench for easyaxi_slv_rd_ctrl: table of single bursts plus outstanding, backpressure and reset sequences.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_slv_rd_ctrl;
  localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  logic arvalid, arready, rvalid, rready, rlast;
  logic [`AXI_ID_W-1:0]    arid, rid;
  logic [`AXI_ADDR_W-1:0]  araddr;
  logic [`AXI_LEN_W-1:0]   arlen;
  logic [`AXI_SIZE_W-1:0]  arsize;
  logic [`AXI_BURST_W-1:0] arburst;
  logic [`AXI_USER_W-1:0]  aruser, ruser;
  logic [`AXI_DATA_W-1:0]  rdata;
  logic [`AXI_RESP_W-1:0]  rresp;

  always #5 clk = ~clk;

  easyaxi_slv_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .axi_slv_arvalid(arvalid), .axi_slv_arready(arready),
    .axi_slv_arid(arid), .axi_slv_araddr(araddr), .axi_slv_arlen(arlen),
    .axi_slv_arsize(arsize), .axi_slv_arburst(arburst), .axi_slv_aruser(aruser),
    .axi_slv_rvalid(rvalid), .axi_slv_rready(rready),
    .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
    .axi_slv_rlast(rlast), .axi_slv_ruser(ruser)
  );

  typedef struct packed {
    logic [3:0]        id;
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [15:0][31:0] d;
    logic [15:0][1:0]  r;
  } vec_t;

  vec_t tbl [8];
  vec_t fl [6];
  vec_t v;
  int   n_chk = 0, n_err = 0;
  int   w, idx, stale;
  logic ph;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                               input logic [2:0] s, input logic [1:0] b, input logic [1:0] rsp);
    vec_t x;
    x = '0;
    x.id = id; x.addr = a; x.len = l; x.size = s; x.burst = b;
    for (int k = 0; k < 16; k++) x.r[k] = rsp;
    return x;
  endfunction

  task automatic send_ar(input vec_t x);
    int t = 0;
    arvalid = 1'b1; arid = x.id; araddr = x.addr; arlen = x.len;
    arsize = x.size; arburst = x.burst; aruser = x.id ^ 4'h5;
    @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (!arready) begin
      n_chk++; n_err++;
      $display("FAIL ar_timeout id=%0d: arready stayed 0, required 1", x.id);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Expects rready=1; returns how many extra cycles the first beat took to appear.
  task automatic collect(input vec_t x, input string tag, output int wait0);
    int t;
    wait0 = -1;
    for (int b = 0; b <= int'(x.len); b++) begin
      t = 0;
      @(negedge clk);
      while (!rvalid && t < 30) begin @(negedge clk); t++; end
      if (b == 0) wait0 = t;
      if (!rvalid) begin
        n_chk++; n_err++;
        $display("FAIL %s_timeout beat %0d: rvalid stayed 0, required 1", tag, b);
        return;
      end
      chk($sformatf("%s_b%0d_data", tag, b), 64'(rdata), 64'(x.d[b]));
      chk($sformatf("%s_b%0d_resp", tag, b), 64'(rresp), 64'(x.r[b]));
      chk($sformatf("%s_b%0d_id",   tag, b), 64'(rid),   64'(x.id));
      chk($sformatf("%s_b%0d_user", tag, b), 64'(ruser), 64'(x.id ^ 4'h5));
      chk($sformatf("%s_b%0d_last", tag, b), 64'(rlast), 64'(b == int'(x.len)));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; aruser = 0;
    rready = 0; rst_n = 0;

    tbl[0] = mkv(4'd1, 32'h10, 8'd3, 3'd2, INCR, OKAY);
    tbl[0].d[0] = 32'h10; tbl[0].d[1] = 32'h14; tbl[0].d[2] = 32'h18; tbl[0].d[3] = 32'h1C;
    tbl[1] = mkv(4'd2, 32'h24, 8'd3, 3'd2, WRAP, OKAY);
    tbl[1].d[0] = 32'h24; tbl[1].d[1] = 32'h28; tbl[1].d[2] = 32'h2C; tbl[1].d[3] = 32'h20;
    tbl[2] = mkv(4'd3, 32'h24, 8'd2, 3'd2, WRAP, SLVERR);
    tbl[2].d[0] = 32'h24; tbl[2].d[1] = 32'h28; tbl[2].d[2] = 32'h2C;
    tbl[3] = mkv(4'd4, 32'h30, 8'd3, 3'd2, FIXED, OKAY);
    tbl[3].d[0] = 32'h30; tbl[3].d[1] = 32'h30; tbl[3].d[2] = 32'h30; tbl[3].d[3] = 32'h30;
    tbl[4] = mkv(4'd5, 32'h40, 8'd8, 3'd2, INCR, SLVERR);
    tbl[4].d[0] = 32'h40; tbl[4].d[1] = 32'h44; tbl[4].d[2] = 32'h48; tbl[4].d[3] = 32'h4C;
    tbl[4].d[4] = 32'h50; tbl[4].d[5] = 32'h54; tbl[4].d[6] = 32'h58; tbl[4].d[7] = 32'h5C;
    tbl[4].d[8] = 32'h60;
    tbl[5] = mkv(4'd6, 32'h50, 8'd1, 3'd2, RSVD, SLVERR);
    tbl[5].d[0] = 32'h50; tbl[5].d[1] = 32'h54;
    tbl[6] = mkv(4'd7, 32'hFE, 8'd2, 3'd0, INCR, OKAY);
    tbl[6].d[0] = 32'hFE; tbl[6].d[1] = 32'hFF; tbl[6].d[2] = 32'h0; tbl[6].r[2] = DECERR;
    tbl[7] = mkv(4'd8, 32'h1C, 8'd1, 3'd3, WRAP, OKAY);
    tbl[7].d[0] = 32'h1C; tbl[7].d[1] = 32'h14;

    #2;
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_rvalid",  64'(rvalid),  64'd0);
    chk("rst_rlast",   64'(rlast),   64'd0);
    chk("rst_rid",     64'(rid),     64'd0);
    chk("rst_rdata",   64'(rdata),   64'd0);
    chk("rst_rresp",   64'(rresp),   64'd0);
    chk("rst_ruser",   64'(ruser),   64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    rready = 1;
    for (int i = 0; i < 8; i++) begin
      send_ar(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_lat_idle", i), 64'(rvalid), 64'd0);
      collect(tbl[i], $sformatf("v%0d", i), w);
      chk($sformatf("v%0d_first_wait", i), 64'(w), 64'd0);
    end

    // Outstanding: id0 is taken into the beat FSM, ids 1-4 fill the queue, id5 must stall.
    rready = 0;
    for (int k = 0; k < 6; k++) begin
      fl[k] = mkv(4'(k), 32'h80 + 32'h10 * 32'(k), 8'd1, 3'd2, INCR, OKAY);
      fl[k].d[0] = fl[k].addr;
      fl[k].d[1] = fl[k].addr + 32'h4;
    end
    for (int k = 0; k < 5; k++) send_ar(fl[k]);
    @(negedge clk);
    chk("full_arready", 64'(arready), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("full_hold%0d_arready", c), 64'(arready), 64'd0);
      chk($sformatf("full_hold%0d_rvalid", c),  64'(rvalid),  64'd1);
      chk($sformatf("full_hold%0d_rdata", c),   64'(rdata),   64'h80);
    end
    @(posedge clk); #1;
    fork
      begin
        rready = 1;
        for (int k = 0; k < 6; k++) begin
          if (k > 0) begin
            @(negedge clk);
            chk($sformatf("ost%0d_gap", k), 64'(rvalid), 64'd0);
          end
          collect(fl[k], $sformatf("ost%0d", k), w);
          chk($sformatf("ost%0d_first_wait", k), 64'(w), 64'd0);
        end
      end
      send_ar(fl[5]);
    join

    // Decode boundary with rready toggling; stalled cycles must still show the current beat.
    rready = 0;
    v = mkv(4'd11, 32'hF8, 8'd3, 3'd2, INCR, OKAY);
    v.d[0] = 32'hF8; v.d[1] = 32'hFC; v.d[2] = 32'h0; v.d[3] = 32'h0;
    v.r[2] = DECERR; v.r[3] = DECERR;
    send_ar(v);
    idx = 0; ph = 1'b1;
    for (int c = 0; c < 40 && idx < 4; c++) begin
      rready = ph;
      @(negedge clk);
      if (rvalid) begin
        chk($sformatf("bp_c%0d_data", c), 64'(rdata), 64'(v.d[idx]));
        chk($sformatf("bp_c%0d_resp", c), 64'(rresp), 64'(v.r[idx]));
        chk($sformatf("bp_c%0d_last", c), 64'(rlast), 64'(idx == 3));
        if (rready) idx++;
      end
      ph = ~ph;
      @(posedge clk); #1;
    end
    chk("bp_beats", 64'(idx), 64'd4);

    // Reset in the middle of a burst with two requests still queued.
    rready = 0;
    v = mkv(4'd8, 32'h10, 8'd3, 3'd2, INCR, OKAY);
    send_ar(v);
    send_ar(mkv(4'd9, 32'h20, 8'd3, 3'd2, INCR, OKAY));
    send_ar(mkv(4'd10, 32'h30, 8'd3, 3'd2, INCR, OKAY));
    @(negedge clk);
    chk("mid_rvalid", 64'(rvalid), 64'd1);
    chk("mid_rdata0", 64'(rdata),  64'h10);
    @(posedge clk); #1;
    rready = 1;
    repeat (2) @(posedge clk);
    #1 rready = 0;
    @(negedge clk);
    chk("mid_rdata2", 64'(rdata), 64'h18);
    chk("mid_rid",    64'(rid),   64'd8);
    #1 rst_n = 0;
    #1;
    chk("arst_rvalid",  64'(rvalid),  64'd0);
    chk("arst_arready", 64'(arready), 64'd1);
    chk("arst_rlast",   64'(rlast),   64'd0);
    chk("arst_rid",     64'(rid),     64'd0);
    chk("arst_rdata",   64'(rdata),   64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    rready = 1;
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (rvalid) stale++;
    end
    chk("arst_no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;
    v = mkv(4'd7, 32'h60, 8'd1, 3'd2, INCR, OKAY);
    v.d[0] = 32'h60; v.d[1] = 32'h64;
    send_ar(v);
    @(negedge clk);
    chk("post_lat_idle", 64'(rvalid), 64'd0);
    collect(v, "post", w);
    chk("post_first_wait", 64'(w), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
